wb_reg_write: RTL and testbench

WB_REG_WRITE -- requirements
Module: wb_reg_write

---
 rtl/wb_reg_write_pkg.sv | 13 +
 rtl/wb_reg_write_if.sv | 29 ++
 rtl/wb_reg_write_decoder_5to32.sv | 16 +
 rtl/wb_reg_write.sv | 60 ++++++
 tb/tb_wb_reg_write.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/wb_reg_write_pkg.sv
// rtl/wb_reg_write_pkg.sv - shared MIPS datapath constants and write-back helpers
package wb_reg_write_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_CNT = 32;

    // Register 0 is hard-wired to zero, so a write to it is never enabled.
    function automatic logic rf_write_en(logic valid, logic reg_write, logic rd_is_zero);
        return valid & reg_write & ~rd_is_zero;
    endfunction

endpackage

// File: rtl/wb_reg_write_if.sv
// rtl/wb_reg_write_if.sv - memory-stage inputs and register-file write outputs of write-back
interface wb_reg_write_if #(
    parameter int DATA_W  = wb_reg_write_pkg::DATA_W,
    parameter int ADDR_W  = wb_reg_write_pkg::ADDR_W,
    parameter int REG_CNT = wb_reg_write_pkg::REG_CNT
);
    logic              mem_valid;
    logic              mem_regWrite;
    logic              mem_memtoReg;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_readData;

    logic               regWrite;
    logic [REG_CNT-1:0] decOut;
    logic [DATA_W-1:0]  d;
    logic [ADDR_W-1:0]  wb_rd;
    logic               wb_valid;

    modport master (
        output mem_valid, mem_regWrite, mem_memtoReg, mem_rd, mem_aluResult, mem_readData,
        input  regWrite, decOut, d, wb_rd, wb_valid
    );

    modport slave (
        input  mem_valid, mem_regWrite, mem_memtoReg, mem_rd, mem_aluResult, mem_readData,
        output regWrite, decOut, d, wb_rd, wb_valid
    );
endinterface

// File: rtl/wb_reg_write_decoder_5to32.sv
// rtl/wb_reg_write_decoder_5to32.sv - one-hot register select decoder with enable
module decoder_5to32
    import wb_reg_write_pkg::*;
#(
    parameter int ADDR_W  = wb_reg_write_pkg::ADDR_W,
    parameter int REG_CNT = wb_reg_write_pkg::REG_CNT
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic               enable,
    output logic [REG_CNT-1:0] dec_out
);

    // Shifting a single set bit guarantees at most one bit is ever high.
    assign dec_out = enable ? (REG_CNT'(1) << addr) : '0;

endmodule

// File: rtl/wb_reg_write.sv
// rtl/wb_reg_write.sv - write-back stage: captures memory-stage result and drives register-file write port
module wb_reg_write
    import wb_reg_write_pkg::*;
#(
    parameter int DATA_W  = wb_reg_write_pkg::DATA_W,
    parameter int ADDR_W  = wb_reg_write_pkg::ADDR_W,
    parameter int REG_CNT = wb_reg_write_pkg::REG_CNT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    wb_reg_write_if.slave bus
);

    logic              valid_q;
    logic              reg_write_q;
    logic              memto_reg_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_en;

    // Flush only kills the valid bit; payload is don't-care once invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            rd_q        <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= bus.mem_valid;
            reg_write_q <= bus.mem_regWrite;
            memto_reg_q <= bus.mem_memtoReg;
            rd_q        <= bus.mem_rd;
            alu_q       <= bus.mem_aluResult;
            rdata_q     <= bus.mem_readData;
        end
    end

    assign wr_en        = rf_write_en(valid_q, reg_write_q, rd_q == '0);
    assign bus.regWrite = wr_en;
    assign bus.wb_valid = valid_q;
    assign bus.wb_rd    = rd_q;
    assign bus.d        = memto_reg_q ? rdata_q : alu_q;

    decoder_5to32 #(
        .ADDR_W  (ADDR_W),
        .REG_CNT (REG_CNT)
    ) u_dec (
        .addr    (rd_q),
        .enable  (wr_en),
        .dec_out (bus.decOut)
    );

endmodule

// File: tb/tb_wb_reg_write.sv
// tb/tb_wb_reg_write.sv - self-checking bench for wb_reg_write
module tb_wb_reg_write;
    import wb_reg_write_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    wb_reg_write_if bus();

    wb_reg_write dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the instruction currently held in write-back.
    bit          m_valid;
    bit          m_rw;
    bit          m_mtr;
    int unsigned m_rd;
    logic [31:0] m_alu;
    logic [31:0] m_rdata;

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_rd = 0; m_alu = '0; m_rdata = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        bit          exp_rw;
        logic [31:0] exp_dec;
        logic [31:0] exp_d;
        exp_rw  = m_valid && m_rw && (m_rd != 0);
        exp_dec = exp_rw ? (32'h1 << m_rd) : 32'h0;
        exp_d   = m_mtr ? m_rdata : m_alu;
        check({tag, "/regWrite"}, 64'(bus.regWrite), 64'(exp_rw));
        check({tag, "/decOut"},   64'(bus.decOut),   64'(exp_dec));
        check({tag, "/d"},        64'(bus.d),        64'(exp_d));
        check({tag, "/wb_valid"}, 64'(bus.wb_valid), 64'(m_valid));
        check({tag, "/wb_rd"},    64'(bus.wb_rd),    64'(m_rd));
        check({tag, "/onehot"},   64'($countones(bus.decOut) <= 1), 64'(1));
    endtask

    task automatic drive(input bit v, input bit rw, input bit mtr, input int unsigned rd,
                         input logic [31:0] alu, input logic [31:0] rdata);
        bus.mem_valid     = v;
        bus.mem_regWrite  = rw;
        bus.mem_memtoReg  = mtr;
        bus.mem_rd        = 5'(rd);
        bus.mem_aluResult = alu;
        bus.mem_readData  = rdata;
    endtask

    // One clock: update the model from the inputs present at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_clear();
        else if (flush) m_valid = 0;
        else if (!stall) begin
            m_valid = bus.mem_valid;
            m_rw    = bus.mem_regWrite;
            m_mtr   = bus.mem_memtoReg;
            m_rd    = 32'(bus.mem_rd);
            m_alu   = bus.mem_aluResult;
            m_rdata = bus.mem_readData;
        end
        #2;
    endtask

    initial begin
        model_clear();
        drive(1, 1, 0, 9, 32'h1111_2222, 32'h3333_4444);

        // Reset held while the clock runs
        repeat (3) begin
            tick();
            check_model("rst_hold");
            check("rst_hold/d_zero", 64'(bus.d), 64'h0);
        end

        drive(0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        check_model("first_edge");
        check("first_edge/regWrite0", 64'(bus.regWrite), 64'h0);
        check("first_edge/d0", 64'(bus.d), 64'h0);

        // Basic write to r5 from the ALU
        drive(1, 1, 0, 5, 32'h0000_00AB, $urandom);
        tick();
        check_model("alu_r5");
        check("alu_r5/regWrite1", 64'(bus.regWrite), 64'h1);
        check("alu_r5/dec20", 64'(bus.decOut), 64'h0000_0020);
        check("alu_r5/dAB", 64'(bus.d), 64'h0000_00AB);

        // Write to r0 is suppressed but the slot is still valid
        drive(1, 1, 0, 0, 32'h0000_00AB, $urandom);
        tick();
        check_model("r0");
        check("r0/wb_valid1", 64'(bus.wb_valid), 64'h1);
        check("r0/regWrite0", 64'(bus.regWrite), 64'h0);
        check("r0/dec0", 64'(bus.decOut), 64'h0);

        // Load to r31, then held through 3 stalls while inputs churn
        drive(1, 1, 1, 31, $urandom, 32'hDEAD_BEEF);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 31), $urandom, $urandom);
            tick();
            check_model("stall");
            check("stall/dec_r31", 64'(bus.decOut), 64'h8000_0000);
            check("stall/d_beef", 64'(bus.d), 64'hDEAD_BEEF);
        end

        // Flush wins over stall
        flush = 1'b1;
        tick();
        check_model("flush_stall");
        check("flush_stall/wb_valid0", 64'(bus.wb_valid), 64'h0);
        check("flush_stall/regWrite0", 64'(bus.regWrite), 64'h0);
        check("flush_stall/dec0", 64'(bus.decOut), 64'h0);
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset between edges
        drive(1, 1, 0, 7, 32'h0000_1234, $urandom);
        tick();
        check("async/pre_regWrite1", 64'(bus.regWrite), 64'h1);
        #1 reset = 1'b0;
        #1 model_clear();
        check_model("async");
        check("async/d0", 64'(bus.d), 64'h0);
        #2 reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31), $urandom, $urandom);
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
